ber_counter_param: RTL and testbench
====================================

Name: ber_counter_param

Overview:
- Parametrised BER counter for one demodulated rail (I or Q). One instance per rail.
- Aligns the received slicer bit stream against the local PRBS reference by sweeping a programmable delay line.
- Locks to the delay with the fewest errors, then accumulates saturating error and bit counts for the BER readout.
- Successor to the fixed 1024-tap, 511-bit-window counter, with configurable depth, window and threshold, valid-qualified comparisons, search-fail reporting and counter clear.

Parameters:
- DEPTH, 1024: reference delay-line length in taps; power of 2, at least 2. DW = $clog2(DEPTH).
- WINDOW, 511: valid bits compared per candidate delay. EW = $clog2(WINDOW+1).
- CNT_W, 64: width of the error and bit counters.
- LOCK_THR, 0: maximum window error count accepted as lock.
- RELOCK_THR, 8: window error count above which lock is dropped (RELOCK_EN only).

Ports:
- clock  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_enable  in  1  global enable; low freezes all state
- i_valid  in  1  sample strobe, qualifies i_rx_bit and i_ref_bit
- i_rx_bit  in  1  slicer output bit
- i_ref_bit  in  1  local PRBS bit
- i_clear  in  1  synchronous clear of o_errors and o_bits
- o_locked  out  1  alignment found
- o_delay  out  DW  selected delay tap (current sweep tap while searching)
- o_search_fail  out  1  one-cycle pulse when a full sweep ends with no tap at or under LOCK_THR
- o_errors  out  CNT_W  accumulated errors since lock or clear
- o_bits  out  CNT_W  accumulated compared bits since lock or clear

Behaviour:
- Reset: the I/O interface uses synchronous reset i_reset, active-high, on clock clock.
- Reset values: state=FILL; delay line, window counter and tap all 0; best_err all-ones; o_locked=0; o_search_fail=0; o_errors=0; o_bits=0.
- i_reset has priority over everything and aborts any state mid-operation.
- All state advances only when i_enable && i_valid ("sample"). With i_enable low, everything holds, including the delay line.
- Delay line: on each sample, sr <= {sr[DEPTH-2:0], i_ref_bit}.
- Error bit: err = i_rx_bit ^ sr[tap], evaluated combinationally before the shift.
- Registered outputs update on the clock edge that consumes the sample, so latency is 1 cycle.
- FILL: count DEPTH samples so the line is fully loaded, then enter SEARCH with tap=0.
- SEARCH:
  - Each sample adds err to win_err (EW bits; it cannot overflow).
  - After WINDOW samples: if win_err < best_err (strict), store best_err=win_err and best_tap=tap. Ties keep the lower tap.
  - Then clear win_err and advance the tap. Tap DEPTH-1 wraps to 0, and that is the sweep end.
  - At sweep end, if best_err <= LOCK_THR: enter LOCKED, set tap=best_tap, o_locked=1, clear o_errors and o_bits.
  - Otherwise pulse o_search_fail for 1 cycle, reset best_err to all-ones and start a new sweep from tap 0 without refilling.
  - The window-end update and the sweep-end decision use the final sample's err in the same cycle.
- LOCKED:
  - Tap is frozen.
  - Each sample: o_bits += 1, o_errors += err.
  - Both counters saturate at 2^CNT_W-1; each holds independently once saturated.
  - Without RELOCK_EN, LOCKED is left only by reset.
- i_clear:
  - Zeroes o_errors and o_bits next cycle, in any state.
  - i_clear wins over a simultaneous sample (that sample is not counted).
  - Does not affect lock, tap or delay line.
- o_delay is the registered tap.
- o_search_fail is 0 in every state except the fail cycle.

Optional Feature:
- Macro BER_RELOCK_EN.
- Defined:
  - LOCKED additionally counts err into win_err over WINDOW-sample windows.
  - If a window ends with win_err > RELOCK_THR: o_locked=0 next cycle and the state goes to SEARCH at tap 0 with best_err all-ones.
  - o_errors and o_bits hold their values and do not count during the search.
  - On re-lock both counters are cleared again.
- Undefined: no window counting in LOCKED; LOCKED is terminal until reset.

Test Plan:
1. Clean lock. DEPTH=16, WINDOW=31, PRBS9 reference, rx = reference delayed 5 samples, valid every cycle. Expect o_locked=1 one cycle after sample 16+16*31=512, o_delay=5, o_errors=0; after 100 more samples o_bits=100.
2. Error injection. Locked as in case 1, flip 3 rx bits. Expect o_errors=3 and o_bits to count every sample; i_clear together with a valid sample gives o_bits=0 and o_errors=0 on the next cycle.
3. Search fail. rx tied to 0 against PRBS9. Expect o_search_fail pulses after sample 512, then after every further 496 samples; o_locked stays 0.
4. Freeze and gaps. Case 1 with i_valid toggled 1/0 and i_enable low for 50 cycles in mid-search. Expect the same lock result (o_delay=5) after 512 valid samples; no state change while disabled.
5. Saturation and reset. CNT_W=4, locked, 20 samples with constant error. Expect o_bits=15 and o_errors=15, both held. Assert i_reset mid-SEARCH in a separate run and expect all outputs at reset values next cycle.
6. BER_RELOCK_EN. Lock at delay 5, then switch rx to delay 9. Expect o_locked=0 after the first window with more than 8 errors, followed by re-lock at o_delay=9 and counters cleared.

Source files
------------

// File: rtl/ber_counter_param.sv
// -----------------------------------------------------------------------------
// ber_counter_param
//
// Bit-error-rate counter for one demodulated rail (instantiate once per I/Q).
// The local PRBS reference is pushed through a DEPTH-tap delay line. After the
// line is filled, every tap is scored over a WINDOW-sample window. The tap with
// the fewest errors is selected; ties go to the lower tap. If that tap scores at
// or under LOCK_THR the block locks and counts errors and compared bits with
// saturating counters. Otherwise it pulses o_search_fail and sweeps again
// without refilling.
//
// All state advances only on a sample (i_enable && i_valid). Outputs are
// registered, so they reflect a sample one clock after it is presented.
//
// Optional feature (compile-time macro BER_RELOCK_EN):
//   When defined, LOCKED keeps scoring WINDOW-sample windows on the locked tap.
//   A window with more than RELOCK_THR errors drops lock and restarts the sweep
//   from tap 0. o_errors/o_bits hold while searching and are cleared on re-lock.
//   When undefined, LOCKED is left only through reset.
//
// Ports:
//   clock          system clock
//   i_reset        synchronous reset, active-high, highest priority
//   i_enable       global enable; low freezes all state
//   i_valid        sample strobe for i_rx_bit / i_ref_bit
//   i_rx_bit       slicer output bit
//   i_ref_bit      local PRBS reference bit
//   i_clear        clears o_errors / o_bits (wins over a simultaneous sample)
//   o_locked       alignment found
//   o_delay        selected tap (current sweep tap while searching)
//   o_search_fail  one-cycle pulse when a sweep ends without an acceptable tap
//   o_errors       saturating error count since lock or clear
//   o_bits         saturating compared-bit count since lock or clear
// -----------------------------------------------------------------------------
module ber_counter_param #(
  parameter int DEPTH      = 1024,
  parameter int WINDOW     = 511,
  parameter int CNT_W      = 64,
  parameter int LOCK_THR   = 0,
  parameter int RELOCK_THR = 8
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic                     i_rx_bit,
  input  logic                     i_ref_bit,
  input  logic                     i_clear,
  output logic                     o_locked,
  output logic [$clog2(DEPTH)-1:0] o_delay,
  output logic                     o_search_fail,
  output logic [CNT_W-1:0]         o_errors,
  output logic [CNT_W-1:0]         o_bits
);

  localparam int DW = $clog2(DEPTH);
  localparam int EW = $clog2(WINDOW + 1);
  // One counter serves both the fill phase (DEPTH samples) and the window
  // phase (WINDOW samples), so it is sized for the larger of the two.
  localparam int CW = (DW > EW) ? DW : EW;

  localparam logic [CW-1:0] FILL_LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] WIN_LAST     = CW'(WINDOW - 1);
  localparam logic [DW-1:0] TAP_LAST     = DW'(DEPTH - 1);
  localparam logic [EW-1:0] LOCK_THR_E   = EW'(LOCK_THR);
  localparam logic [EW-1:0] RELOCK_THR_E = EW'(RELOCK_THR);

`ifdef BER_RELOCK_EN
  localparam logic RELOCK_EN = 1'b1;
`else
  localparam logic RELOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [DEPTH-1:0] sr_q,       sr_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [DW-1:0]    tap_q,      tap_d;
  logic [EW-1:0]    win_err_q,  win_err_d;
  logic [EW-1:0]    best_err_q, best_err_d;
  logic [DW-1:0]    best_tap_q, best_tap_d;
  logic             locked_q,   locked_d;
  logic             fail_q,     fail_d;
  logic [CNT_W-1:0] errors_q,   errors_d;
  logic [CNT_W-1:0] bits_q,     bits_d;

  logic             sample_s;
  logic             err_s;
  logic             win_end_s;
  logic [EW-1:0]    win_next_s;
  logic [EW-1:0]    best_err_new_s;
  logic [DW-1:0]    best_tap_new_s;
  logic             lock_now_s;

  // Saturating increment: holds at all-ones once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  assign sample_s   = i_enable & i_valid;
  // Compare against the tap before this sample's shift.
  assign err_s      = i_rx_bit ^ sr_q[tap_q];
  assign win_end_s  = (cnt_q == WIN_LAST);
  // Window score including the current sample's error bit.
  assign win_next_s = win_err_q + EW'(err_s);

  // Best-so-far including the window that may be ending now; strict compare
  // keeps the lower tap on ties.
  always_comb begin
    best_err_new_s = best_err_q;
    best_tap_new_s = best_tap_q;
    if (win_next_s < best_err_q) begin
      best_err_new_s = win_next_s;
      best_tap_new_s = tap_q;
    end else begin
      best_err_new_s = best_err_q;
      best_tap_new_s = best_tap_q;
    end
  end

  // Alignment state machine: fill, sweep/score taps, locked monitoring.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    tap_d      = tap_q;
    win_err_d  = win_err_q;
    best_err_d = best_err_q;
    best_tap_d = best_tap_q;
    locked_d   = locked_q;
    fail_d     = 1'b0;
    lock_now_s = 1'b0;

    if (sample_s) begin
      sr_d = {sr_q[DEPTH-2:0], i_ref_bit};
      case (state_q)
        ST_FILL: begin
          if (cnt_q == FILL_LAST) begin
            state_d   = ST_SEARCH;
            cnt_d     = {CW{1'b0}};
            tap_d     = {DW{1'b0}};
            win_err_d = {EW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_SEARCH: begin
          if (win_end_s) begin
            cnt_d     = {CW{1'b0}};
            win_err_d = {EW{1'b0}};
            if (tap_q == TAP_LAST) begin
              // Sweep end: decide on the best tap including this window.
              if (best_err_new_s <= LOCK_THR_E) begin
                state_d    = ST_LOCKED;
                tap_d      = best_tap_new_s;
                best_err_d = best_err_new_s;
                best_tap_d = best_tap_new_s;
                locked_d   = 1'b1;
                lock_now_s = 1'b1;
              end else begin
                fail_d     = 1'b1;
                tap_d      = {DW{1'b0}};
                best_err_d = {EW{1'b1}};
              end
            end else begin
              best_err_d = best_err_new_s;
              best_tap_d = best_tap_new_s;
              tap_d      = tap_q + DW'(1);
            end
          end else begin
            cnt_d     = cnt_q + CW'(1);
            win_err_d = win_next_s;
          end
        end

        ST_LOCKED: begin
          if (RELOCK_EN) begin
            if (win_end_s) begin
              cnt_d     = {CW{1'b0}};
              win_err_d = {EW{1'b0}};
              if (win_next_s > RELOCK_THR_E) begin
                state_d    = ST_SEARCH;
                tap_d      = {DW{1'b0}};
                best_err_d = {EW{1'b1}};
                locked_d   = 1'b0;
              end else begin
                locked_d = 1'b1;
              end
            end else begin
              cnt_d     = cnt_q + CW'(1);
              win_err_d = win_next_s;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        default: begin
          state_d  = ST_FILL;
          cnt_d    = {CW{1'b0}};
          tap_d    = {DW{1'b0}};
          locked_d = 1'b0;
        end
      endcase
    end else begin
      sr_d = sr_q;
    end
  end

  // Error/bit counters: clear beats lock entry beats counting.
  always_comb begin
    errors_d = errors_q;
    bits_d   = bits_q;
    if (i_enable && i_clear) begin
      errors_d = {CNT_W{1'b0}};
      bits_d   = {CNT_W{1'b0}};
    end else if (lock_now_s) begin
      errors_d = {CNT_W{1'b0}};
      bits_d   = {CNT_W{1'b0}};
    end else if (sample_s && (state_q == ST_LOCKED)) begin
      errors_d = sat_inc(errors_q, err_s);
      bits_d   = sat_inc(bits_q, 1'b1);
    end else begin
      errors_d = errors_q;
      bits_d   = bits_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_FILL;
      sr_q       <= {DEPTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      tap_q      <= {DW{1'b0}};
      win_err_q  <= {EW{1'b0}};
      best_err_q <= {EW{1'b1}};
      best_tap_q <= {DW{1'b0}};
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      errors_q   <= {CNT_W{1'b0}};
      bits_q     <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
      win_err_q  <= win_err_d;
      best_err_q <= best_err_d;
      best_tap_q <= best_tap_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      errors_q   <= errors_d;
      bits_q     <= bits_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_delay       = tap_q;
  assign o_search_fail = fail_q;
  assign o_errors      = errors_q;
  assign o_bits        = bits_q;

endmodule

// File: tb/tb_ber_counter_param.sv
// -----------------------------------------------------------------------------
// tb_ber_counter_param
//
// Two instances (CNT_W=16 and CNT_W=4) share one stimulus stream. A reference
// model tracks the sample index, the per-tap error totals of the current sweep
// and the true (unbounded) error/bit counts; the expected saturated outputs are
// min(count, 2^CNT_W-1). Expectations are queued per cycle and a separate
// monitor pops and compares them after each clock edge. Directed checks cover
// lock timing, counting, clear, saturation, search fail, freeze and reset.
// -----------------------------------------------------------------------------
module tb_ber_counter_param;

  localparam int DEPTH      = 16;
  localparam int WINDOW     = 31;
  localparam int LOCK_THR   = 0;
  localparam int RELOCK_THR = 8;
  localparam int WA         = 16;
  localparam int WB         = 4;

  logic          clock;
  logic          i_reset, i_enable, i_valid, i_rx_bit, i_ref_bit, i_clear;
  logic          a_locked, a_fail, b_locked, b_fail;
  logic [3:0]    a_delay, b_delay;
  logic [WA-1:0] a_errors, a_bits;
  logic [WB-1:0] b_errors, b_bits;

  ber_counter_param #(.DEPTH(DEPTH), .WINDOW(WINDOW), .CNT_W(WA),
                      .LOCK_THR(LOCK_THR), .RELOCK_THR(RELOCK_THR)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .i_clear(i_clear),
    .o_locked(a_locked), .o_delay(a_delay), .o_search_fail(a_fail),
    .o_errors(a_errors), .o_bits(a_bits));

  ber_counter_param #(.DEPTH(DEPTH), .WINDOW(WINDOW), .CNT_W(WB),
                      .LOCK_THR(LOCK_THR), .RELOCK_THR(RELOCK_THR)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .i_clear(i_clear),
    .o_locked(b_locked), .o_delay(b_delay), .o_search_fail(b_fail),
    .o_errors(b_errors), .o_bits(b_bits));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int n_printed = 0;

  typedef struct {
    bit     locked;
    bit     fail;
    int     delay;
    longint errs;
    longint bits;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- reference model ----------------
  bit     m_hist[$];          // m_hist[k] = reference bit from k+1 samples ago
  int     m_samples;          // samples consumed since reset
  int     m_base;             // sample index where the current sweep began
  int     m_werr[DEPTH];      // errors per tap in the current sweep
  bit     m_locked;
  int     m_lock_tap;
  int     m_lk_base;
  int     m_lk_werr;
  longint m_err, m_bits;
  bit     m_fail;
  int     m_delay;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < DEPTH; i++) m_hist.push_back(1'b0);
    m_samples = 0; m_base = DEPTH; m_locked = 1'b0; m_lock_tap = 0;
    m_lk_base = 0; m_lk_werr = 0; m_err = 0; m_bits = 0; m_fail = 1'b0; m_delay = 0;
    for (int t = 0; t < DEPTH; t++) m_werr[t] = 0;
  endfunction

  function automatic void model_step(bit rst, bit en, bit vld, bit clr, bit rx, bit rf);
    exp_t e;
    int rel, tap, best;
    bit er;
    m_fail = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (en && vld) begin
        if (m_samples >= DEPTH && !m_locked) begin
          rel = m_samples - m_base;
          tap = (rel / WINDOW) % DEPTH;
          er  = rx ^ m_hist[tap];
          m_werr[tap] += int'(er);
          if (((rel + 1) % WINDOW == 0) && (tap == DEPTH - 1)) begin
            best = 0;
            for (int t = 1; t < DEPTH; t++) if (m_werr[t] < m_werr[best]) best = t;
            if (m_werr[best] <= LOCK_THR) begin
              m_locked = 1'b1; m_lock_tap = best; m_err = 0; m_bits = 0;
              m_lk_base = m_samples + 1; m_lk_werr = 0;
            end else begin
              m_fail = 1'b1;
              m_base = m_samples + 1;
            end
            for (int t = 0; t < DEPTH; t++) m_werr[t] = 0;
          end
        end else if (m_locked) begin
          er = rx ^ m_hist[m_lock_tap];
          m_bits += 1;
          m_err  += longint'(er);
`ifdef BER_RELOCK_EN
          m_lk_werr += int'(er);
          if ((m_samples - m_lk_base + 1) % WINDOW == 0) begin
            if (m_lk_werr > RELOCK_THR) begin
              m_locked = 1'b0;
              m_base = m_samples + 1;
              for (int t = 0; t < DEPTH; t++) m_werr[t] = 0;
            end
            m_lk_werr = 0;
          end
`endif
        end
        m_hist.push_front(rf);
        void'(m_hist.pop_back());
        m_samples++;
      end
      if (en && clr) begin
        m_err = 0; m_bits = 0;
      end
      if (m_locked) m_delay = m_lock_tap;
      else if (m_samples < DEPTH) m_delay = 0;
      else m_delay = ((m_samples - m_base) / WINDOW) % DEPTH;
    end
    e.locked = m_locked; e.fail = m_fail; e.delay = m_delay;
    e.errs = m_err; e.bits = m_bits;
    sb_q.push_back(e);
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  bit [8:0] prbs = 9'h1FF;
  bit       tb_hist[$];

  // PRBS9, x^9 + x^5 + 1
  function automatic bit prbs_next();
    bit nb;
    nb   = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], nb};
    return nb;
  endfunction

  // tap < 0 ties rx low; otherwise rx is the reference held at that tap.
  task automatic cyc(input bit rst, input bit en, input bit vld, input bit clr,
                     input int tap, input bit flip);
    bit rxb, refb, smp;
    @(negedge clock);
    smp = en && vld && !rst;
    if (smp) begin
      refb = prbs_next();
      if (tap < 0) rxb = 1'b0;
      else rxb = ((tap < tb_hist.size()) ? tb_hist[tap] : 1'b0) ^ flip;
    end else begin
      refb = 1'($urandom_range(0, 1));
      rxb  = 1'($urandom_range(0, 1));
    end
    i_reset = rst; i_enable = en; i_valid = vld; i_clear = clr;
    i_rx_bit = rxb; i_ref_bit = refb;
    model_step(rst, en, vld, clr, rxb, refb);
    if (rst) tb_hist.delete();
    else if (smp) begin
      tb_hist.push_front(refb);
      if (tb_hist.size() > DEPTH + 4) void'(tb_hist.pop_back());
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec += 2;
        if (a_locked !== e.locked || a_fail !== e.fail || int'(a_delay) != e.delay ||
            longint'(a_errors) != sat(e.errs, WA) || longint'(a_bits) != sat(e.bits, WA)) begin
          n_bad++;
          if (n_printed < 20) begin
            n_printed++;
            $display("FAIL sb_a t=%0t: got lk=%0b fl=%0b dl=%0d er=%0d bt=%0d want lk=%0b fl=%0b dl=%0d er=%0d bt=%0d",
                     $time, a_locked, a_fail, a_delay, a_errors, a_bits,
                     e.locked, e.fail, e.delay, sat(e.errs, WA), sat(e.bits, WA));
          end
        end
        if (b_locked !== e.locked || b_fail !== e.fail || int'(b_delay) != e.delay ||
            longint'(b_errors) != sat(e.errs, WB) || longint'(b_bits) != sat(e.bits, WB)) begin
          n_bad++;
          if (n_printed < 20) begin
            n_printed++;
            $display("FAIL sb_b t=%0t: got lk=%0b fl=%0b dl=%0d er=%0d bt=%0d want lk=%0b fl=%0b dl=%0d er=%0d bt=%0d",
                     $time, b_locked, b_fail, b_delay, b_errors, b_bits,
                     e.locked, e.fail, e.delay, sat(e.errs, WB), sat(e.bits, WB));
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lock_at, unlock_at, first_fail, second_fail, vcnt, tap;
    bit ever_locked, relocked, v, en, vl, cl, fl;

    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
    i_rx_bit = 1'b0; i_ref_bit = 1'b0;
    model_reset();

    // Reset state
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    settle();
    chk("rst_locked", a_locked, 0); chk("rst_delay", a_delay, 0);
    chk("rst_fail", a_fail, 0); chk("rst_errors", a_errors, 0); chk("rst_bits", a_bits, 0);

    // Clean lock at tap 5
    lock_at = 0;
    for (int n = 1; n <= 1000 && lock_at == 0; n++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b0);
      settle();
      if (a_locked) lock_at = n;
    end
    chk("lock_sample", lock_at, 512);
    chk("lock_delay", a_delay, 5);
    chk("lock_errors", a_errors, 0);
    repeat (100) cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b0);
    settle();
    chk("bits_100", a_bits, 100);
    chk("errors_clean", a_errors, 0);

    // Error injection, then clear together with a sample
    for (int n = 0; n < 20; n++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, (n == 3 || n == 9 || n == 15));
    settle();
    chk("inj_errors", a_errors, 3);
    chk("inj_bits", a_bits, 120);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1);
    settle();
    chk("clear_errors", a_errors, 0);
    chk("clear_bits", a_bits, 0);

    // Saturation on the 4-bit instance
    repeat (20) cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b1);
    settle();
    chk("sat_b_bits", b_bits, 15); chk("sat_b_errors", b_errors, 15);
    chk("wide_a_bits", a_bits, 20); chk("wide_a_errors", a_errors, 20);

    // Alignment moves to tap 9
`ifdef BER_RELOCK_EN
    unlock_at = 0;
    for (int n = 1; n <= 300 && unlock_at == 0; n++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 9, 1'b0);
      settle();
      if (!a_locked) unlock_at = n;
    end
    chk("unlock_seen", (unlock_at != 0), 1);
    relocked = 1'b0;
    for (int n = 1; n <= 1200 && !relocked; n++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 9, 1'b0);
      settle();
      if (a_locked) relocked = 1'b1;
    end
    chk("relock_seen", relocked, 1);
    chk("relock_delay", a_delay, 9);
    chk("relock_errors", a_errors, 0);
    chk("relock_bits", b_bits, 0);
`else
    repeat (600) cyc(1'b0, 1'b1, 1'b1, 1'b0, 9, 1'b0);
    settle();
    chk("stay_locked", a_locked, 1);
    chk("stay_delay", a_delay, 5);
    chk("stay_bits", a_bits, 620);
    chk("stay_b_bits", b_bits, 15);
`endif

    // Search fail with rx tied low
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    first_fail = 0; second_fail = 0; ever_locked = 1'b0;
    for (int n = 1; n <= 1100; n++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
      settle();
      if (a_fail) begin
        if (first_fail == 0) first_fail = n;
        else if (second_fail == 0) second_fail = n;
      end
      if (a_locked) ever_locked = 1'b1;
    end
    chk("fail_first", first_fail, 512);
    chk("fail_second", second_fail, 1008);
    chk("fail_no_lock", ever_locked, 0);

    // Valid gaps and a 50-cycle disable during the sweep
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    vcnt = 0;
    for (int n = 0; n < 4000 && vcnt < 511; n++) begin
      if (vcnt == 200) begin
        repeat (50) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 5, 1'b0);
        vcnt++;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b0);
      end else begin
        v = 1'($urandom_range(0, 1));
        cyc(1'b0, 1'b1, v, 1'b0, 5, 1'b0);
        if (v) vcnt++;
      end
    end
    settle();
    chk("gap_no_early_lock", a_locked, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5, 1'b0);
    settle();
    chk("gap_locked", a_locked, 1);
    chk("gap_delay", a_delay, 5);

    // Reset in the middle of a sweep
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    repeat (300) cyc(1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    settle();
    chk("pre_rst_delay", a_delay, 9);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    settle();
    chk("mid_rst_delay", a_delay, 0); chk("mid_rst_locked", a_locked, 0);
    chk("mid_rst_fail", a_fail, 0); chk("mid_rst_bits", a_bits, 0);

    // Randomised soak against the model
    for (int c = 0; c < 3; c++) begin
      tap = $urandom_range(0, DEPTH - 1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
      for (int n = 0; n < 1200; n++) begin
        en = ($urandom_range(0, 7) != 0);
        vl = ($urandom_range(0, 3) != 0);
        cl = en && ($urandom_range(0, 299) == 0);
        fl = ($urandom_range(0, 399) == 0);
        cyc(1'b0, en, vl, cl, tap, fl);
      end
    end
    settle();
    settle();
    chk("sb_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
